// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: multi-cycle multiply/divide unit holding the architectural
// HI/LO registers.
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request strobe from the decoder, sampled on the rising edge
//   op     - 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, else none
//   a, b   - rs / rt operands, latched when the request is accepted
//   hi, lo - HI/LO registers
//   busy   - operation in flight; the pipeline stalls on it
//   done   - one-cycle pulse after HI/LO were written by a multiply or divide
module mips_cpu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   op_a;       // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0]   op_b;       // multiplier, or divisor magnitude
    logic [WIDTH-1:0]   acc;        // partial remainder
    logic [CNT_W-1:0]   count;
    logic               mul_signed;
    logic               q_neg;
    logic               r_neg;

    logic [2*WIDTH-1:0] ext_a, ext_b, product;
    logic [WIDTH:0]     acc_sh;
    logic               ge;
    logic [WIDTH-1:0]   acc_nx;

    assign busy = (state != IDLE);

    // Sign- or zero-extending to 2*WIDTH makes a plain truncated multiply
    // give the correct full-width product for both signednesses.
    always_comb begin
        ext_a   = mul_signed ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
        ext_b   = mul_signed ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
        product = ext_a * ext_b;
    end

    // Restoring step. The shifted remainder needs WIDTH+1 bits; when its top
    // bit is set it certainly exceeds the divisor, and the difference always
    // fits back into WIDTH bits, so only the low bits are subtracted.
    always_comb begin
        acc_sh = {acc, op_a[WIDTH-1]};
        ge     = acc_sh[WIDTH] | (acc_sh[WIDTH-1:0] >= op_b);
        acc_nx = ge ? (acc_sh[WIDTH-1:0] - op_b) : acc_sh[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: state_nx = MUL;
                        OP_DIV,  OP_DIVU:  state_nx = DIV;
                        default:           state_nx = IDLE;
                    endcase
                end
            end
            MUL: state_nx = IDLE;
            DIV: if (count == CNT_W'(WIDTH - 1)) state_nx = FIX;
            FIX: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi         <= '0;
            lo         <= '0;
            done       <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            acc        <= '0;
            count      <= '0;
            mul_signed <= 1'b0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                op_a       <= a;
                                op_b       <= b;
                                mul_signed <= (op == OP_MULT);
                            end
                            OP_DIV: begin
                                op_a  <= a[WIDTH-1] ? -a : a;
                                op_b  <= b[WIDTH-1] ? -b : b;
                                q_neg <= a[WIDTH-1] ^ b[WIDTH-1];
                                r_neg <= a[WIDTH-1];
                                acc   <= '0;
                                count <= '0;
                            end
                            OP_DIVU: begin
                                op_a  <= a;
                                op_b  <= b;
                                q_neg <= 1'b0;
                                r_neg <= 1'b0;
                                acc   <= '0;
                                count <= '0;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    {hi, lo} <= product;
                    done     <= 1'b1;
                end
                DIV: begin
                    acc   <= acc_nx;
                    op_a  <= {op_a[WIDTH-2:0], ge};
                    count <= count + 1'b1;
                end
                FIX: begin
                    lo   <= q_neg ? -op_a : op_a;
                    hi   <= r_neg ? -acc  : acc;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
module tb_mips_cpu_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    mips_cpu_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: results straight from integer arithmetic.
    task automatic model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                         output logic [31:0] rhi, output logic [31:0] rlo, output int lat);
        longint x, y, p, q, r;
        rhi = '0; rlo = '0; lat = 0;
        case (mop)
            3'b001, 3'b010: begin
                x = (mop == 3'b001) ? longint'(int'(ma)) : longint'(ma);
                y = (mop == 3'b001) ? longint'(int'(mb)) : longint'(mb);
                p = x * y;
                rhi = 32'(p >>> 32);
                rlo = 32'(p);
                lat = 1;
            end
            3'b011: begin
                if (mb == 0) begin
                    rhi = ma;
                    rlo = (int'(ma) < 0) ? 32'd1 : 32'hFFFF_FFFF;
                end else begin
                    x = longint'(int'(ma));
                    y = longint'(int'(mb));
                    q = x / y;
                    r = x % y;
                    rlo = 32'(q);
                    rhi = 32'(r);
                end
                lat = 33;
            end
            3'b100: begin
                if (mb == 0) begin
                    rhi = ma;
                    rlo = 32'hFFFF_FFFF;
                end else begin
                    rlo = ma / mb;
                    rhi = ma % mb;
                end
                lat = 33;
            end
            default: ;
        endcase
    endtask

    // Issue one mult/div from idle, scramble the inputs, wait for completion.
    task automatic run_op(input string tag, input logic [2:0] mop,
                          input logic [31:0] ma, input logic [31:0] mb);
        logic [31:0] ehi, elo;
        int lat, n;
        model(mop, ma, mb, ehi, elo, lat);
        start = 1'b1; op = mop; a = ma; b = mb;
        tick();
        start = 1'b0; op = 3'b000; a = $urandom; b = $urandom;
        chk({tag, ".busy_on"}, 32'(busy), 32'd1);
        chk({tag, ".done_lo"}, 32'(done), 32'd0);
        chk({tag, ".hi_held"}, hi, cur_hi);
        chk({tag, ".lo_held"}, lo, cur_lo);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(lat));
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".hi"}, hi, ehi);
        chk({tag, ".lo"}, lo, elo);
        cur_hi = ehi; cur_lo = elo;
        tick();
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] ehi, elo, ra, rb;
        logic [2:0]  rop;
        int lat, n, dones;

        // Reset state
        #2;
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Multiply
        run_op("mult_neg2x3",  3'b001, 32'hFFFF_FFFE, 32'd3);
        run_op("multu_neg2x3", 3'b010, 32'hFFFF_FFFE, 32'd3);

        // Divide
        run_op("div_m7_2",   3'b011, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2.lo_lit", lo, 32'hFFFF_FFFD);
        chk("div_m7_2.hi_lit", hi, 32'hFFFF_FFFF);
        run_op("divu_100_7", 3'b100, 32'd100, 32'd7);
        run_op("div_ovf",    3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf.lo_lit", lo, 32'h8000_0000);
        chk("div_ovf.hi_lit", hi, 32'd0);
        run_op("divu_5_0",   3'b100, 32'd5, 32'd0);
        run_op("div_m5_0",   3'b011, 32'hFFFF_FFFB, 32'd0);
        chk("div_m5_0.lo_lit", lo, 32'd1);
        run_op("div_7_0",    3'b011, 32'd7, 32'd0);

        // Start during busy: the MULT must be dropped
        start = 1'b1; op = 3'b100; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0; op = 3'b000;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) dones++;
            tick();
        end
        start = 1'b1; op = 3'b001; a = 32'd3; b = 32'd3;
        tick();
        start = 1'b0; op = 3'b000;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            tick();
        end
        chk("busy_ignore.hi", hi, 32'd2);
        chk("busy_ignore.lo", lo, 32'd14);
        chk("busy_ignore.dones", 32'(dones), 32'd1);
        chk("busy_ignore.idle", 32'(busy), 32'd0);
        cur_hi = 32'd2; cur_lo = 32'd14;

        // MTHI then MTLO on consecutive cycles
        start = 1'b1; op = 3'b101; a = 32'h1234_5678;
        tick();
        chk("mthi.hi", hi, 32'h1234_5678);
        chk("mthi.lo", lo, cur_lo);
        chk("mthi.busy", 32'(busy), 32'd0);
        chk("mthi.done", 32'(done), 32'd0);
        op = 3'b110; a = 32'hCAFE_BABE;
        tick();
        start = 1'b0; op = 3'b000;
        chk("mtlo.lo", lo, 32'hCAFE_BABE);
        chk("mtlo.hi", hi, 32'h1234_5678);
        chk("mtlo.busy", 32'(busy), 32'd0);
        chk("mtlo.done", 32'(done), 32'd0);
        cur_hi = 32'h1234_5678; cur_lo = 32'hCAFE_BABE;
        // no-op codes leave everything alone
        start = 1'b1; op = 3'b111; a = 32'd9;
        tick();
        op = 3'b000;
        tick();
        start = 1'b0;
        chk("nop.hi", hi, cur_hi);
        chk("nop.busy", 32'(busy), 32'd0);

        // Back-to-back MULT issued in the done cycle
        start = 1'b1; op = 3'b001; a = 32'hFFFF_FFFE; b = 32'd3;
        tick();
        start = 1'b0;
        tick();
        chk("b2b.done1", 32'(done), 32'd1);
        chk("b2b.lo1", lo, 32'hFFFF_FFFA);
        start = 1'b1; op = 3'b001; a = 32'd5; b = 32'hFFFF_FFF9;
        tick();
        start = 1'b0; op = 3'b000;
        chk("b2b.busy2", 32'(busy), 32'd1);
        chk("b2b.done_gap", 32'(done), 32'd0);
        tick();
        chk("b2b.done2", 32'(done), 32'd1);
        chk("b2b.hi2", hi, 32'hFFFF_FFFF);
        chk("b2b.lo2", lo, 32'hFFFF_FFDD);
        cur_hi = hi === 32'hFFFF_FFFF ? 32'hFFFF_FFFF : 32'hFFFF_FFFF;
        cur_lo = 32'hFFFF_FFDD;
        tick();

        // Random operations against the reference
        for (int i = 0; i < 24; i++) begin
            rop = 3'(1 + $urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            run_op("rand", rop, ra, rb);
        end

        // Asynchronous reset in the middle of a divide
        start = 1'b1; op = 3'b100; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0; op = 3'b000;
        for (int i = 0; i < 9; i++) tick();
        chk("rstmid.busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid.hi", hi, 32'd0);
        chk("rstmid.lo", lo, 32'd0);
        chk("rstmid.busy", 32'(busy), 32'd0);
        chk("rstmid.done", 32'(done), 32'd0);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) dones++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) dones++;
        end
        chk("rstmid.no_done", 32'(dones), 32'd0);
        chk("rstmid.hi_after", hi, 32'd0);
        cur_hi = '0; cur_lo = '0;
        run_op("post_rst_divu", 3'b100, 32'd1000, 32'd33);
        model(3'b010, 32'hDEAD_BEEF, 32'h1234_5678, ehi, elo, lat);
        run_op("post_rst_multu", 3'b010, 32'hDEAD_BEEF, 32'h1234_5678);
        n = lat;
        chk("post_rst.lat_model", 32'(n), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
